mskaes_128bits_round_ctrl: RTL

//  Sequencer for the masked 128-bit AES round datapath (one full round per iteration: AK, SB, SR, MC

---
 rtl/mskaes_128bits_round_ctrl_if.sv | 52 +++++
 rtl/mskaes_128bits_round_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mskaes_128bits_round_ctrl_if.sv
// Control bundle between the masked AES-128 round sequencer and its datapath/environment.
// The sequencer uses the slave modport; the environment driving jobs uses master.
interface mskaes_128bits_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       abort;
    logic       rnd_valid;
    logic       rnd_req;
    logic       state_en;
    logic [1:0] state_sel;
    logic       key_en;
    logic       key_sel;
    logic [7:0] rcon;
    logic [3:0] round_idx;
    logic       busy;

    modport master (
        output in_valid,
        output out_ready,
        output abort,
        output rnd_valid,
        input  in_ready,
        input  out_valid,
        input  rnd_req,
        input  state_en,
        input  state_sel,
        input  key_en,
        input  key_sel,
        input  rcon,
        input  round_idx,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        input  abort,
        input  rnd_valid,
        output in_ready,
        output out_valid,
        output rnd_req,
        output state_en,
        output state_sel,
        output key_en,
        output key_sel,
        output rcon,
        output round_idx,
        output busy
    );
endinterface

// File: rtl/mskaes_128bits_round_ctrl.sv
// Sequencer for the masked AES-128 round datapath: 10 iterations of LATENCY cycles each,
// then holds the ciphertext under valid/ready. Control only, no shares pass through here.
module mskaes_128bits_round_ctrl #(
    parameter int unsigned LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    mskaes_128bits_round_ctrl_if.slave   bus_io
);
    localparam int unsigned CntW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);
    localparam logic [3:0] LastRound  = 4'd9;

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      round_q, round_d;

    logic       in_ready;
    logic       out_valid;
    logic       rnd_req;
    logic       state_en;
    logic [1:0] state_sel;
    logic       key_en;
    logic       key_sel;
    logic [7:0] rcon;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rnd_req   = 1'b0;
        state_en  = 1'b0;
        state_sel = 2'd0;
        key_en    = 1'b0;
        key_sel   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = ~bus_io.abort;
                if (bus_io.in_valid && !bus_io.abort) begin
                    state_en = 1'b1;
                    key_en   = 1'b1;
                    state_d  = StRound;
                    cnt_d    = '0;
                    round_d  = '0;
                end
            end
            StRound: begin
                rnd_req = 1'b1;
                // Starved cycle: the round restarts; its inputs are still in the registers.
                if (!bus_io.rnd_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_en  = 1'b1;
                    key_en    = 1'b1;
                    key_sel   = 1'b1;
                    state_sel = (round_q == LastRound) ? 2'd2 : 2'd1;
                    cnt_d     = '0;
                    if (round_q == LastRound) begin
                        state_d = StDone;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                    round_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over accept, commit and completion alike.
        if (bus_io.abort) begin
            state_d   = StIdle;
            cnt_d     = '0;
            round_d   = '0;
            state_en  = 1'b0;
            key_en    = 1'b0;
            state_sel = 2'd0;
            key_sel   = 1'b0;
        end
    end

    always_comb begin
        rcon = 8'h00;
        unique case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid;
    assign bus_io.rnd_req   = rnd_req;
    assign bus_io.state_en  = state_en;
    assign bus_io.state_sel = state_sel;
    assign bus_io.key_en    = key_en;
    assign bus_io.key_sel   = key_sel;
    assign bus_io.rcon      = rcon;
    assign bus_io.round_idx = round_q;
    assign bus_io.busy      = (state_q != StIdle);

endmodule
